// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, default widths, flag layout and the
// arbiter priority state type.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_e;

  function automatic logic [2:0] pack_flags(input logic z, input logic n, input logic v);
    logic [2:0] f;
    f         = 3'b000;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: combinational grant from the eligible vector,
// with a one-bit priority FSM favouring the requester that lost last time.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] eligible,
  output logic [1:0] grant
);
  import alu_pkg::*;

  pri_e state_r;
  pri_e state_s;

  // priority state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= PRI0;
    end else begin
      state_r <= state_s;
    end
  end

  // grant selection and next priority state
  always_comb begin
    grant   = 2'b00;
    state_s = state_r;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (state_r == PRI1) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    if (grant[0]) begin
      state_s = PRI1;
    end else if (grant[1]) begin
      state_s = PRI0;
    end else begin
      state_s = state_r;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two valid/ready requesters and captures
// results into per-requester response registers. Optional counters: ALU_ARB_STATS_EN.
module alu_arbiter #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int OP_W   = alu_pkg::OP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [OP_W-1:0]   req_op1,
  input  logic              req_sw0,
  input  logic              req_sw1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_o0,
  output logic [DATA_W-1:0] rsp_o1,
  output logic [2:0]        rsp_flags0,
  output logic [2:0]        rsp_flags1,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_sw,
  input  logic [DATA_W-1:0] alu_o,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_v
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0]       grant_cnt0,
  output logic [31:0]       grant_cnt1,
  output logic [31:0]       stall_cnt
`endif
);
  import alu_pkg::*;

  logic [1:0] eligible_s;
  logic [1:0] grant_s;

  // A slot is free when empty or being drained this cycle; nothing is granted in reset.
  assign eligible_s = req_valid & (~rsp_valid | rsp_ready) & {2{~reset}};
  assign req_ready  = grant_s;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .reset    (reset),
    .eligible (eligible_s),
    .grant    (grant_s)
  );

  // ALU operand steering from the granted requester
  always_comb begin
    alu_a  = {DATA_W{1'b0}};
    alu_b  = {DATA_W{1'b0}};
    alu_op = {OP_W{1'b0}};
    alu_sw = 1'b0;
    if (grant_s[0]) begin
      alu_a  = req_a0;
      alu_b  = req_b0;
      alu_op = req_op0;
      alu_sw = req_sw0;
    end else if (grant_s[1]) begin
      alu_a  = req_a1;
      alu_b  = req_b1;
      alu_op = req_op1;
      alu_sw = req_sw1;
    end else begin
      alu_a  = {DATA_W{1'b0}};
      alu_b  = {DATA_W{1'b0}};
      alu_op = {OP_W{1'b0}};
      alu_sw = 1'b0;
    end
  end

  // response registers: a new grant overrides consumption in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= 2'b00;
      rsp_o0     <= {DATA_W{1'b0}};
      rsp_o1     <= {DATA_W{1'b0}};
      rsp_flags0 <= 3'b000;
      rsp_flags1 <= 3'b000;
    end else begin
      if (grant_s[0]) begin
        rsp_valid[0] <= 1'b1;
        rsp_o0       <= alu_o;
        rsp_flags0   <= pack_flags(alu_z, alu_n, alu_v);
      end else if (rsp_ready[0]) begin
        rsp_valid[0] <= 1'b0;
      end
      if (grant_s[1]) begin
        rsp_valid[1] <= 1'b1;
        rsp_o1       <= alu_o;
        rsp_flags1   <= pack_flags(alu_z, alu_n, alu_v);
      end else if (rsp_ready[1]) begin
        rsp_valid[1] <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  // grant and stall counters, free-running with natural wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= 32'd0;
      grant_cnt1 <= 32'd0;
      stall_cnt  <= 32'd0;
    end else begin
      if (grant_s[0]) grant_cnt0 <= grant_cnt0 + 32'd1;
      if (grant_s[1]) grant_cnt1 <= grant_cnt1 + 32'd1;
      if (|(req_valid & ~grant_s)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: models the external ALU, runs directed
// scenarios then random traffic against a scoreboard of expected responses.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic [2:0]  req_op0, req_op1;
  logic        req_sw0, req_sw1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_o0, rsp_o1;
  logic [2:0]  rsp_flags0, rsp_flags1;
  logic [31:0] alu_a, alu_b, alu_o;
  logic [2:0]  alu_op;
  logic        alu_sw, alu_z, alu_n, alu_v;
  logic [34:0] alu_res;
`ifdef ALU_ARB_STATS_EN
  logic [31:0] grant_cnt0, grant_cnt1, stall_cnt;
  int          m_g0, m_g1, m_stall;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] o;
    logic [2:0]  f;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [1:0] m_valid;
  int         m_favour;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1), .req_sw0(req_sw0), .req_sw1(req_sw1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_o0(rsp_o0), .rsp_o1(rsp_o1), .rsp_flags0(rsp_flags0), .rsp_flags1(rsp_flags1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sw(alu_sw),
    .alu_o(alu_o), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .stall_cnt(stall_cnt)
`endif
  );

  // Reference ALU: returns {result, Z, N, V}
  function automatic logic [34:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input logic sw);
    logic [31:0] r;
    logic        v;
    v = 1'b0;
    case (op)
      3'd0: begin
        if (sw) begin
          r = a - b;
          v = (a[31] != b[31]) && (r[31] != a[31]);
        end else begin
          r = a + b;
          v = (a[31] == b[31]) && (r[31] != a[31]);
        end
      end
      3'd1: r = a << b[4:0];
      3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: r = sw ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return {r, (r == 32'd0), r[31], v};
  endfunction

  assign alu_res = alu_ref(alu_a, alu_b, alu_op, alu_sw);
  assign alu_o   = alu_res[34:3];
  assign alu_z   = alu_res[2];
  assign alu_n   = alu_res[1];
  assign alu_v   = alu_res[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Reference arbitration: expected grants, occupancy, and scoreboard pushes
  always @(negedge clk) begin
    logic [1:0]  elig;
    logic [1:0]  g;
    logic [34:0] r;
    if (reset) begin
      q0.delete();
      q1.delete();
      m_valid  = 2'b00;
      m_favour = 0;
`ifdef ALU_ARB_STATS_EN
      m_g0 = 0; m_g1 = 0; m_stall = 0;
`endif
      chk("req_ready_in_reset", 32'(req_ready), 32'd0);
    end else begin
      elig = req_valid & (~m_valid | rsp_ready);
      if (elig == 2'b11) g = (m_favour == 0) ? 2'b01 : 2'b10;
      else               g = elig;
      chk("req_ready_model", 32'(req_ready), 32'(g));
      chk("rsp_valid_model", 32'(rsp_valid), 32'(m_valid));
      if (g[0]) begin
        r = alu_ref(req_a0, req_b0, req_op0, req_sw0);
        q0.push_back('{o: r[34:3], f: r[2:0]});
        m_favour = 1;
      end
      if (g[1]) begin
        r = alu_ref(req_a1, req_b1, req_op1, req_sw1);
        q1.push_back('{o: r[34:3], f: r[2:0]});
        m_favour = 0;
      end
      for (int i = 0; i < 2; i++) begin
        if (g[i]) m_valid[i] = 1'b1;
        else if (rsp_ready[i]) m_valid[i] = 1'b0;
      end
`ifdef ALU_ARB_STATS_EN
      if (g[0]) m_g0++;
      if (g[1]) m_g1++;
      if (|(req_valid & ~g)) m_stall++;
`endif
    end
  end

  // Monitor: every response is checked at the cycle it is consumed
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (rsp_valid[0] && rsp_ready[0]) begin
        if (q0.size() == 0) begin
          chk("rsp0_unexpected", 32'd1, 32'd0);
        end else begin
          e = q0.pop_front();
          chk("rsp_o0", rsp_o0, e.o);
          chk("rsp_flags0", 32'(rsp_flags0), 32'(e.f));
        end
      end
      if (rsp_valid[1] && rsp_ready[1]) begin
        if (q1.size() == 0) begin
          chk("rsp1_unexpected", 32'd1, 32'd0);
        end else begin
          e = q1.pop_front();
          chk("rsp_o1", rsp_o1, e.o);
          chk("rsp_flags1", 32'(rsp_flags1), 32'(e.f));
        end
      end
    end
  end

  initial begin
    logic [1:0] acc;
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_a0 = 32'd0; req_b0 = 32'd0; req_op0 = 3'd0; req_sw0 = 1'b0;
    req_a1 = 32'd0; req_b1 = 32'd0; req_op1 = 3'd0; req_sw1 = 1'b0;
    step(); step();
    req_valid = 2'b11;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_o0", rsp_o0, 32'd0);
    chk("reset_rsp_o1", rsp_o1, 32'd0);
    chk("reset_flags", 32'({rsp_flags0, rsp_flags1}), 32'd0);
    chk("reset_alu_a", alu_a, 32'd0);

    // single requester 0: 5 + 3
    step(); reset = 1'b0; req_valid = 2'b01; rsp_ready = 2'b11;
    req_a0 = 32'd5; req_b0 = 32'd3; req_op0 = 3'd0; req_sw0 = 1'b0;
    @(negedge clk); chk("add_grant0", 32'(req_ready), 32'd1);
    step(); req_valid = 2'b00;
    @(negedge clk);
    chk("add_valid", 32'(rsp_valid), 32'd1);
    chk("add_o0", rsp_o0, 32'd8);
    chk("add_flags0", 32'(rsp_flags0), 32'd0);

    // single requester 1: overflow add, then equal subtract
    step(); req_valid = 2'b10;
    req_a1 = 32'h7FFF_FFFF; req_b1 = 32'd1; req_op1 = 3'd0; req_sw1 = 1'b0;
    @(negedge clk); chk("ovf_grant1", 32'(req_ready), 32'd2);
    step(); req_a1 = 32'd7; req_b1 = 32'd7; req_sw1 = 1'b1;
    @(negedge clk);
    chk("ovf_o1", rsp_o1, 32'h8000_0000);
    chk("ovf_flags1", 32'(rsp_flags1), 32'd3);
    chk("sub_grant1", 32'(req_ready), 32'd2);
    step(); req_valid = 2'b00;
    @(negedge clk);
    chk("sub_o1", rsp_o1, 32'd0);
    chk("sub_flags1", 32'(rsp_flags1), 32'd4);

    // contention: alternating grants, requester 1 does an arithmetic shift
    step(); req_valid = 2'b11;
    req_a0 = 32'd100; req_b0 = 32'd23; req_op0 = 3'd0; req_sw0 = 1'b0;
    req_a1 = 32'h8000_0000; req_b1 = 32'd4; req_op1 = 3'd5; req_sw1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("alternate", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k == 2) chk("sra_o1", rsp_o1, 32'hF800_0000);
      step();
    end
    req_valid = 2'b00;
    step();

    // backpressure on requester 0
    req_valid = 2'b01; req_a0 = 32'd1; req_b0 = 32'd2;
    @(negedge clk); chk("bp_first", 32'(req_ready), 32'd1);
    step(); req_valid = 2'b11; req_a0 = 32'd10; req_b0 = 32'd20; rsp_ready = 2'b10;
    @(negedge clk);
    chk("bp_block0", 32'(req_ready), 32'd2);
    chk("bp_hold0", rsp_o0, 32'd3);
    step();
    @(negedge clk);
    chk("bp_block0_b", 32'(req_ready), 32'd2);
    chk("bp_hold0_b", rsp_o0, 32'd3);
    step(); rsp_ready = 2'b11;
    @(negedge clk); chk("bp_release", 32'(req_ready), 32'd1);
    step(); req_valid = 2'b00;
    @(negedge clk); chk("bp_new_o0", rsp_o0, 32'd30);

    // reset with both responses pending and priority at PRI1
    step(); rsp_ready = 2'b00; req_valid = 2'b10;
    @(negedge clk); chk("rst_fill1", 32'(req_ready), 32'd2);
    step(); req_valid = 2'b11;
    @(negedge clk); chk("rst_fill0", 32'(req_ready), 32'd1);
    step();
    @(negedge clk);
    chk("rst_full", 32'(rsp_valid), 32'd3);
    chk("rst_full_stall", 32'(req_ready), 32'd0);
    step(); reset = 1'b1;
    @(negedge clk); chk("rst_gate", 32'(req_ready), 32'd0);
    step();
    @(negedge clk);
    chk("rst_cleared", 32'(rsp_valid), 32'd0);
    chk("rst_no_ready", 32'(req_ready), 32'd0);
    step(); reset = 1'b0; rsp_ready = 2'b11;
    @(negedge clk); chk("rst_pri0", 32'(req_ready), 32'd1);
    step(); req_valid = 2'b00;
    step();

    // random traffic, request side obeying the hold rule
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_ready;
      step();
      if (!req_valid[0] || acc[0]) begin
        req_valid[0] = ($urandom_range(0, 3) != 0);
        req_a0 = rand_word(); req_b0 = rand_word();
        req_op0 = 3'($urandom_range(0, 7)); req_sw0 = 1'($urandom_range(0, 1));
      end
      if (!req_valid[1] || acc[1]) begin
        req_valid[1] = ($urandom_range(0, 3) != 0);
        req_a1 = rand_word(); req_b1 = rand_word();
        req_op1 = 3'($urandom_range(0, 7)); req_sw1 = 1'($urandom_range(0, 1));
      end
      rsp_ready[0] = ($urandom_range(0, 3) != 0);
      rsp_ready[1] = ($urandom_range(0, 3) != 0);
    end

    // drain
    req_valid = 2'b00; rsp_ready = 2'b11;
    step(); step(); step();
    @(negedge clk);
    chk("drain_q0", 32'(q0.size()), 32'd0);
    chk("drain_q1", 32'(q1.size()), 32'd0);
    chk("drain_valid", 32'(rsp_valid), 32'd0);
`ifdef ALU_ARB_STATS_EN
    chk("grant_cnt0", grant_cnt0, 32'(m_g0));
    chk("grant_cnt1", grant_cnt1, 32'(m_g1));
    chk("stall_cnt", stall_cnt, 32'(m_stall));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Round-robin arbiter sharing the single 32-bit ALU between two requesters, e.g. the execute stage and a multi-cycle address/branch unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block drives the ALU operand/control ports and captures its combinational result and flags into a per-requester response register.
- The ALU itself stays outside this block.

Parameters:
- DATA_W, 32, operand/result width.
- OP_W, 3, ALU operation-select width (000 add/sub, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  2  per-requester request valid, bit i = requester i.
- req_ready  output  2  per-requester request accepted this cycle.
- req_a0, req_a1  input  DATA_W  operand A for requester 0/1.
- req_b0, req_b1  input  DATA_W  operand B for requester 0/1.
- req_op0, req_op1  input  OP_W  ALU operation for requester 0/1.
- req_sw0, req_sw1  input  1  ALU switch bit (sub / arithmetic shift) for requester 0/1.
- rsp_valid  output  2  response held for requester i.
- rsp_ready  input  2  requester i consumes its response.
- rsp_o0, rsp_o1  output  DATA_W  registered ALU result for requester 0/1.
- rsp_flags0, rsp_flags1  output  3  registered {Z,N,V} for requester 0/1.
- alu_a, alu_b  output  DATA_W  ALU operand drive.
- alu_op  output  OP_W  ALU operation drive.
- alu_sw  output  1  ALU switch drive.
- alu_o  input  DATA_W  ALU result, combinational from alu_*.
- alu_z, alu_n, alu_v  input  1  ALU flags, combinational.

Behaviour:
- Reset: req_ready=0, rsp_valid=0, rsp_o*=0, rsp_flags*=0, priority state=PRI0.
- Alu_* outputs are combinational from the granted request, and are 0 when there is no grant.
- Slot free for requester i: rsp_valid[i]==0, or (rsp_valid[i]==1 and rsp_ready[i]==1) in the same cycle.
- Eligible for requester i: req_valid[i] and slot i free.
- Grant: at most one per cycle, combinational.
  - Only one requester eligible: that requester is granted.
  - Both eligible: the priority state decides. PRI0 favours 0; PRI1 favours 1.
  - req_ready = grant vector, so at most one bit is set per cycle.
- Priority FSM (states PRI0, PRI1):
  - Grant to 0 -> PRI1.
  - Grant to 1 -> PRI0.
  - No grant -> hold.
- Latency: a request accepted at edge k has rsp_valid[i]=1, and rsp_o/rsp_flags captured from alu_*, visible after edge k.
- Response register: holds its value while rsp_valid[i]=1 and rsp_ready[i]=0.
- Consume without new grant: rsp_valid[i] clears on the edge where rsp_ready[i]=1 and no new grant to i.
- Consume and re-grant in the same cycle: rsp_valid stays 1 and the data is replaced; back-to-back throughput is 1 per cycle per requester.
- rsp_ready[i] while rsp_valid[i]=0: ignored.
- Flags: V is passed through unchanged from the ALU. It is meaningful only for op 000; the ALU returns 0 otherwise.
- Request-side rule: a requester must hold req_* stable while req_valid=1 and req_ready=0. The arbiter does not check this.
- Reset mid-operation: pending responses are discarded, rsp_valid is cleared and priority returns to PRI0 in the same edge.
- Reset dominates all other events.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- When defined, adds outputs grant_cnt0 and grant_cnt1 (32 bits each) and stall_cnt (32 bits). All three reset to 0.
  - grant_cnt0/grant_cnt1 increment per grant to requester 0/1.
  - stall_cnt increments each cycle where some req_valid[i]=1 and req_ready[i]=0.
  - All counters wrap from 0xFFFFFFFF to 0.
- When not defined, these ports and their logic are absent; nothing else changes.

Decomposition:
- Shared package alu_pkg holds:
  - ALU opcode localparams: OP_ADD=000, OP_SLL=001, OP_SLT=010, OP_SLTU=011, OP_XOR=100, OP_SRL=101, OP_OR=110, OP_AND=111.
  - DATA_W and OP_W defaults.
  - Flag bit indices: FLAG_Z=2, FLAG_N=1, FLAG_V=0.
- One sub-module is natural: rr_arb2, a 2-way round-robin grant with the priority FSM. The response registers stay in alu_arbiter.

Test Plan:
- After reset, req0 only: a=5, b=3, op=000, sw=0 -> req_ready=01 in that cycle; next cycle rsp_valid=01, rsp_o0=8, flags0=000.
- req1 only: a=0x7FFFFFFF, b=1, op=000, sw=0 -> rsp_o1=0x80000000, flags1=011 (N=1, V=1). Then a=7, b=7, sw=1 -> rsp_o1=0, flags1=100.
- Both requesters valid continuously, rsp_ready=11 -> grants alternate 0,1,0,1 starting from 0 after reset; each response is correct. Check req1 op=101, sw=1, a=0x80000000, b=4 -> 0xF8000000.
- Backpressure: rsp_valid0=1 with rsp_ready0=0 and req0 valid -> req_ready0=0 and rsp_o0 held; requester 1 is still granted every cycle. When rsp_ready0 rises, req0 is granted in that same cycle.
- Reset asserted with rsp_valid=11 and both requests pending -> next cycle rsp_valid=00, req_ready=00, and first post-reset contention goes to requester 0.
- With ALU_ARB_STATS_EN: 3 grants to 0, 2 to 1, 4 stall cycles -> grant_cnt0=3, grant_cnt1=2, stall_cnt=4. Preload grant_cnt0=0xFFFFFFFF, one grant -> 0.
